// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO family.
// Read-mode encodings, default geometry and a clog2 variant that never returns 0.
package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  localparam int FIFO_DEF_WIDTH = 32;
  localparam int FIFO_DEF_DEPTH = 16;

  // Bits needed to index 'value' entries; at least 1 so a 1-bit pointer still exists.
  function automatic int clog2_min1(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) r = i + 1;
    end
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/synch_fifo_mem.sv
// DEPTH x WIDTH storage for synch_fifo_prog: synchronous write port, asynchronous read port.
// Contents are never reset.
module synch_fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_DEF_WIDTH,
  parameter int DEPTH = FIFO_DEF_DEPTH,
  parameter int PTR_W = clog2_min1(FIFO_DEF_DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [PTR_W-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/synch_fifo_prog.sv
// Parametrised single-clock FIFO: arbitrary depth, programmable almost flags,
// standard or first-word-fall-through read, sticky error flags and synchronous flush.
module synch_fifo_prog
  import fifo_pkg::*;
#(
  parameter int WIDTH     = FIFO_DEF_WIDTH,
  parameter int DEPTH     = FIFO_DEF_DEPTH,
  parameter int FWFT      = FIFO_MODE_STD,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 2,
  localparam int PTR_W    = clog2_min1(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             clr_err,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [PTR_W:0]   data_avail,
  output logic [PTR_W:0]   room_avail,
  output logic             overflow,
  output logic             underflow
);

  if (DEPTH < 2 || AFULL_TH < 1 || AFULL_TH > DEPTH ||
      AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1 ||
      (FWFT != FIFO_MODE_STD && FWFT != FIFO_MODE_FWFT)) begin : g_bad_param
    $error("synch_fifo_prog: illegal DEPTH/FWFT/AFULL_TH/AEMPTY_TH combination");
  end

  localparam logic [PTR_W:0]   DEPTH_C  = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   AFULL_C  = (PTR_W + 1)'(AFULL_TH);
  localparam logic [PTR_W:0]   AEMPTY_C = (PTR_W + 1)'(AEMPTY_TH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W:0]   count_reg, count_next;
  logic             overflow_reg, overflow_next;
  logic             underflow_reg, underflow_next;
  logic             wr_acc, rd_acc;
  logic [WIDTH-1:0] mem_rd_data;

  assign full         = (count_reg == DEPTH_C);
  assign empty        = (count_reg == '0);
  assign almost_full  = (count_reg >= AFULL_C);
  assign almost_empty = (count_reg <= AEMPTY_C);
  assign data_avail   = count_reg;
  assign room_avail   = DEPTH_C - count_reg;
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

  // Flush swallows both requests so nothing moves and no error is latched that cycle.
  assign wr_acc = wr_en & ~full & ~flush;
  assign rd_acc = rd_en & ~empty & ~flush;

  always_comb begin
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    count_next     = count_reg;
    overflow_next  = overflow_reg;
    underflow_next = underflow_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (wr_acc) wr_ptr_next = (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + PTR_W'(1);
      if (rd_acc) rd_ptr_next = (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + PTR_W'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count_next = count_reg + (PTR_W + 1)'(1);
        2'b01:   count_next = count_reg - (PTR_W + 1)'(1);
        default: count_next = count_reg;
      endcase
      // Clear first so a same-cycle error re-sets the flag.
      if (clr_err) begin
        overflow_next  = 1'b0;
        underflow_next = 1'b0;
      end
      if (wr_en & full)  overflow_next  = 1'b1;
      if (rd_en & empty) underflow_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  synch_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr_reg),
    .wr_data (wr_data),
    .rd_addr (rd_ptr_reg),
    .rd_data (mem_rd_data)
  );

  if (FWFT == FIFO_MODE_STD) begin : g_std_read
    logic [WIDTH-1:0] rd_data_reg;
    logic             rd_valid_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_data_reg  <= '0;
        rd_valid_reg <= 1'b0;
      end else begin
        rd_valid_reg <= rd_acc;
        if (rd_acc) rd_data_reg <= mem_rd_data;
      end
    end

    assign rd_data  = rd_data_reg;
    assign rd_valid = rd_valid_reg;
  end else begin : g_fwft_read
    // Head of queue is always presented; rd_en only acknowledges it.
    assign rd_data  = mem_rd_data;
    assign rd_valid = ~empty;
  end

endmodule

// File: tb/tb_synch_fifo_prog.sv
// Directed bench for synch_fifo_prog: three instances (default std, DEPTH=5 std, FWFT)
// with a data scoreboard checked by a negedge monitor.
module tb_synch_fifo_prog;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, clr_err;
  logic [2:0]  wr_en, rd_en;
  logic [31:0] wr_data;

  logic [31:0] rd_data [3];
  logic [2:0]  rd_valid, full, empty, afull, aempty, ovf, unf;
  logic [4:0]  avail0, room0, avail2, room2;
  logic [3:0]  avail1, room1;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [31:0] q0[$], q1[$], q2[$];

  always #5 clk = ~clk;

  synch_fifo_prog u_std (
    .clk(clk), .rst_n(rst_n), .flush(flush), .clr_err(clr_err),
    .wr_en(wr_en[0]), .wr_data(wr_data), .rd_en(rd_en[0]),
    .rd_data(rd_data[0]), .rd_valid(rd_valid[0]), .full(full[0]), .empty(empty[0]),
    .almost_full(afull[0]), .almost_empty(aempty[0]), .data_avail(avail0),
    .room_avail(room0), .overflow(ovf[0]), .underflow(unf[0]));

  synch_fifo_prog #(.DEPTH(5), .AFULL_TH(4), .AEMPTY_TH(1)) u_small (
    .clk(clk), .rst_n(rst_n), .flush(flush), .clr_err(clr_err),
    .wr_en(wr_en[1]), .wr_data(wr_data), .rd_en(rd_en[1]),
    .rd_data(rd_data[1]), .rd_valid(rd_valid[1]), .full(full[1]), .empty(empty[1]),
    .almost_full(afull[1]), .almost_empty(aempty[1]), .data_avail(avail1),
    .room_avail(room1), .overflow(ovf[1]), .underflow(unf[1]));

  synch_fifo_prog #(.FWFT(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .flush(flush), .clr_err(clr_err),
    .wr_en(wr_en[2]), .wr_data(wr_data), .rd_en(rd_en[2]),
    .rd_data(rd_data[2]), .rd_valid(rd_valid[2]), .full(full[2]), .empty(empty[2]),
    .almost_full(afull[2]), .almost_empty(aempty[2]), .data_avail(avail2),
    .room_avail(room2), .overflow(ovf[2]), .underflow(unf[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: std instances present data on rd_valid; FWFT word is consumed on rd_valid & rd_en.
  always @(negedge clk) begin
    if (rd_valid[0]) begin
      if (q0.size() == 0) check("std_unexpected_valid", {31'd0, rd_valid[0]}, 32'd0);
      else begin
        $display("std   read 0x%0h", rd_data[0]);
        check("std_rd_data", rd_data[0], q0.pop_front());
      end
    end
    if (rd_valid[1]) begin
      if (q1.size() == 0) check("small_unexpected_valid", {31'd0, rd_valid[1]}, 32'd0);
      else begin
        $display("small read 0x%0h", rd_data[1]);
        check("small_rd_data", rd_data[1], q1.pop_front());
      end
    end
    if (rd_valid[2] && rd_en[2]) begin
      if (q2.size() == 0) check("fwft_unexpected_valid", {31'd0, rd_valid[2]}, 32'd0);
      else begin
        $display("fwft  read 0x%0h", rd_data[2]);
        check("fwft_rd_data", rd_data[2], q2.pop_front());
      end
    end
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; clr_err = 1'b0;
    wr_en = '0; rd_en = '0; wr_data = '0;
    #12;
    check("rst_empty", {31'd0, empty[0]}, 32'd1);
    check("rst_aempty", {31'd0, aempty[0]}, 32'd1);
    check("rst_full", {31'd0, full[0]}, 32'd0);
    check("rst_afull", {31'd0, afull[0]}, 32'd0);
    check("rst_room", {27'd0, room0}, 32'd16);
    check("rst_avail", {27'd0, avail0}, 32'd0);
    check("rst_rd_valid", {29'd0, rd_valid}, 32'd0);
    check("rst_rd_data", rd_data[0], 32'd0);
    check("rst_errs", {30'd0, ovf[0], unf[0]}, 32'd0);
    check("rst_small_room", {28'd0, room1}, 32'd5);
    #1 rst_n = 1'b1;
    tick();

    // Fill the default FIFO, then one write too many.
    for (int i = 0; i < 16; i++) begin
      wr_en[0] = 1'b1; wr_data = 32'(i); q0.push_back(32'(i));
      tick();
      check("fill_avail", {27'd0, avail0}, 32'(i + 1));
      check("fill_afull", {31'd0, afull[0]}, {31'd0, (i + 1 >= 12)});
    end
    check("fill_full", {31'd0, full[0]}, 32'd1);
    check("fill_room", {27'd0, room0}, 32'd0);
    wr_data = 32'hDEAD;
    tick();
    wr_en[0] = 1'b0;
    check("ovf_set", {31'd0, ovf[0]}, 32'd1);
    check("ovf_avail", {27'd0, avail0}, 32'd16);

    // Drain; data checked by the monitor one cycle after each rd_en.
    rd_en[0] = 1'b1;
    repeat (16) tick();
    rd_en[0] = 1'b0;
    tick();
    check("drain_empty", {31'd0, empty[0]}, 32'd1);
    rd_en[0] = 1'b1;
    tick();
    rd_en[0] = 1'b0;
    check("unf_set", {31'd0, unf[0]}, 32'd1);
    check("unf_hold_data", rd_data[0], 32'h0F);
    check("unf_no_valid", {31'd0, rd_valid[0]}, 32'd0);

    // Simultaneous read/write at empty, mid-level and full.
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    check("clr_err1", {30'd0, ovf[0], unf[0]}, 32'd0);
    wr_en[0] = 1'b1; rd_en[0] = 1'b1; wr_data = 32'h40; q0.push_back(32'h40);
    tick();
    rd_en[0] = 1'b0;
    check("sim_empty_avail", {27'd0, avail0}, 32'd1);
    check("sim_empty_unf", {31'd0, unf[0]}, 32'd1);
    wr_data = 32'h41; q0.push_back(32'h41); tick();
    wr_data = 32'h42; q0.push_back(32'h42); tick();
    rd_en[0] = 1'b1; wr_data = 32'h43; q0.push_back(32'h43);
    tick();
    wr_en[0] = 1'b0;
    check("sim_mid_avail", {27'd0, avail0}, 32'd3);
    repeat (3) tick();
    rd_en[0] = 1'b0;
    tick();
    check("sim_mid_empty", {31'd0, empty[0]}, 32'd1);
    clr_err = 1'b1; wr_en[0] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_data = 32'h50 + 32'(i); q0.push_back(wr_data);
      tick();
      clr_err = 1'b0;
    end
    rd_en[0] = 1'b1; wr_data = 32'hEE;
    tick();
    wr_en[0] = 1'b0;
    check("sim_full_avail", {27'd0, avail0}, 32'd15);
    check("sim_full_ovf", {31'd0, ovf[0]}, 32'd1);
    check("sim_full_unf", {31'd0, unf[0]}, 32'd0);
    repeat (15) tick();
    rd_en[0] = 1'b0;
    tick();
    check("sim_full_drained", {31'd0, empty[0]}, 32'd1);

    // DEPTH=5: pointers wrap while order is preserved.
    wr_en[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_data = 32'h100 + 32'(i); q1.push_back(wr_data);
      tick();
    end
    wr_en[1] = 1'b0;
    check("small_full", {31'd0, full[1]}, 32'd1);
    check("small_room", {28'd0, room1}, 32'd0);
    rd_en[1] = 1'b1;
    tick();
    check("small_afull", {31'd0, afull[1]}, 32'd1);
    wr_en[1] = 1'b1;
    for (int i = 5; i < 12; i++) begin
      wr_data = 32'h100 + 32'(i); q1.push_back(wr_data);
      tick();
      check("small_avail", {28'd0, avail1}, 32'd4);
    end
    wr_en[1] = 1'b0;
    repeat (4) tick();
    rd_en[1] = 1'b0;
    tick();
    check("small_empty", {31'd0, empty[1]}, 32'd1);
    check("small_ovf", {31'd0, ovf[1]}, 32'd0);

    // FWFT: word appears without rd_en; rd_en acknowledges it.
    check("fwft_idle_valid", {31'd0, rd_valid[2]}, 32'd0);
    wr_en[2] = 1'b1; wr_data = 32'hA5; q2.push_back(32'hA5);
    tick();
    wr_en[2] = 1'b0;
    check("fwft_valid", {31'd0, rd_valid[2]}, 32'd1);
    check("fwft_data", rd_data[2], 32'hA5);
    rd_en[2] = 1'b1;
    tick();
    rd_en[2] = 1'b0;
    check("fwft_empty", {31'd0, empty[2]}, 32'd1);
    check("fwft_valid_low", {31'd0, rd_valid[2]}, 32'd0);
    wr_en[2] = 1'b1;
    wr_data = 32'hB0; q2.push_back(32'hB0); tick();
    wr_data = 32'hB1; q2.push_back(32'hB1); tick();
    wr_en[2] = 1'b0; rd_en[2] = 1'b1;
    repeat (2) tick();
    rd_en[2] = 1'b0;
    check("fwft_empty2", {31'd0, empty[2]}, 32'd1);

    // Flush at count 7 alongside a write; sticky overflow survives.
    wr_en[0] = 1'b1;
    for (int i = 0; i < 7; i++) begin
      wr_data = 32'h60 + 32'(i);
      tick();
    end
    check("pre_flush_avail", {27'd0, avail0}, 32'd7);
    flush = 1'b1; wr_data = 32'h77;
    tick();
    flush = 1'b0; wr_en[0] = 1'b0;
    check("flush_avail", {27'd0, avail0}, 32'd0);
    check("flush_empty", {31'd0, empty[0]}, 32'd1);
    check("flush_ovf_kept", {31'd0, ovf[0]}, 32'd1);
    wr_en[0] = 1'b1; wr_data = 32'h88; q0.push_back(32'h88);
    tick();
    wr_en[0] = 1'b0; rd_en[0] = 1'b1;
    tick();
    rd_en[0] = 1'b0;
    tick();
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    check("clr_err2", {30'd0, ovf[0], unf[0]}, 32'd0);

    // Asynchronous reset with a read in flight.
    wr_en[0] = 1'b1;
    wr_data = 32'h90; q0.push_back(32'h90); tick();
    wr_data = 32'h91; q0.push_back(32'h91); tick();
    wr_en[0] = 1'b0; rd_en[0] = 1'b1;
    tick();
    rd_en[0] = 1'b0;
    #2 rst_n = 1'b0;
    q0.delete();
    #1;
    check("arst_empty", {31'd0, empty[0]}, 32'd1);
    check("arst_avail", {27'd0, avail0}, 32'd0);
    check("arst_room", {27'd0, room0}, 32'd16);
    check("arst_rd_valid", {31'd0, rd_valid[0]}, 32'd0);
    check("arst_rd_data", rd_data[0], 32'd0);
    check("arst_flags", {28'd0, full[0], afull[0], aempty[0], ovf[0]}, 32'b0010);
    #3 rst_n = 1'b1;
    tick();
    tick();
    check("q0_drained", q0.size(), 32'd0);
    check("q1_drained", q1.size(), 32'd0);
    check("q2_drained", q2.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/synch_fifo_prog.md
Name: synch_fifo_prog

Overview:
Parametrised synchronous single-clock FIFO, the successor to the basic 32x16 FIFO. Adds:
- any depth, not just powers of two
- true full at DEPTH entries
- programmable almost-full/almost-empty thresholds
- standard or first-word-fall-through (FWFT) read mode
- sticky overflow/underflow flags and a synchronous flush

Sits between producer/consumer pipeline stages in the same clock domain.

Parameters:
- WIDTH, 32: data width in bits.
- DEPTH, 16: number of entries; any integer >= 2.
- FWFT, 0: 0 = standard registered read; 1 = first-word-fall-through.
- AFULL_TH, 12: almost_full asserted when count >= AFULL_TH; range 1..DEPTH.
- AEMPTY_TH, 2: almost_empty asserted when count <= AEMPTY_TH; range 0..DEPTH-1.
- Localparam PTR_W = clog2(DEPTH), with a minimum of 1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of pointers and count.
- clr_err  in  1  synchronous clear of the sticky error flags.
- wr_en  in  1  write request.
- wr_data  in  WIDTH  write data.
- rd_en  in  1  read request (pop/acknowledge in FWFT mode).
- rd_data  out  WIDTH  read data.
- rd_valid  out  1  rd_data qualifier.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AFULL_TH.
- almost_empty  out  1  count <= AEMPTY_TH.
- data_avail  out  PTR_W+1  current count.
- room_avail  out  PTR_W+1  DEPTH - count.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.

Behaviour:
- Reset (rst_n low, asynchronous):
  - wr_ptr, rd_ptr and count = 0; rd_data = 0; rd_valid = 0.
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0.
  - room_avail = DEPTH; overflow = underflow = 0.
  - Memory contents are not reset.
- Accept rules, evaluated on registered state in the same cycle:
  - wr_acc = wr_en & ~full
  - rd_acc = rd_en & ~empty
- Write: on wr_acc, mem[wr_ptr] <= wr_data; wr_ptr advances.
- Read: on rd_acc, rd_ptr advances.
- Pointer wrap: explicit, DEPTH-1 -> 0. Modulo on non-power-of-two DEPTH is forbidden.
- Count update:
  - +1 on wr_acc only; -1 on rd_acc only; unchanged when both are accepted.
  - Count never exceeds DEPTH and never goes below 0.
- Simultaneous read and write:
  - When empty: write accepted, read rejected; underflow set. No write-to-read bypass.
  - When full: read accepted, write rejected; overflow set.
  - Otherwise both accepted.
- Status flags: combinational decode of the count register. They update in the cycle after the causing edge, with no lookahead.
- Standard mode (FWFT=0):
  - On rd_acc, rd_data <= mem[rd_ptr] at the same edge; rd_valid pulses high for that one following cycle.
  - rd_data holds its value otherwise.
  - Read latency is 1 cycle.
- FWFT mode (FWFT=1):
  - rd_data = mem[rd_ptr] combinationally; rd_valid = ~empty.
  - rd_en acknowledges the presented word.
  - A word written into an empty FIFO appears on rd_data in the cycle after the write edge.
- Sticky errors:
  - overflow set on wr_en & full; underflow set on rd_en & empty.
  - Both held until clr_err or reset.
  - If clr_err and a new error occur in the same cycle, the error wins (set has priority).
- Flush:
  - Priority over wr_en/rd_en in that cycle: pointers and count go to 0; wr/rd requests in that cycle are ignored.
  - rd_valid is cleared; rd_data, mem and the sticky flags are unchanged.
- Reset mid-operation: immediate return to reset state; any in-flight read is discarded.
- Elaboration check: illegal AFULL_TH/AEMPTY_TH values stop elaboration with an error.

Decomposition:
- Shared package fifo_pkg holds:
  - FIFO_MODE_STD = 0 and FIFO_MODE_FWFT = 1
  - the clog2 helper function
  - the default WIDTH/DEPTH constants
- One sub-module, synch_fifo_mem: DEPTH x WIDTH register array with one synchronous write port and one asynchronous read port. The top level owns pointers, count, flags and the read register.

Test Plan:
1. Defaults, FWFT=0, write 16 words 0x00..0x0F with no reads -> full=1 after the 16th edge, almost_full=1 from count 12, room_avail=0. A 17th write -> overflow=1, count stays 16.
2. From full, read 16 words -> rd_data sequence 0x00..0x0F, each with a one-cycle rd_valid pulse one cycle after rd_en; empty=1 at the end. A further read -> underflow=1, rd_data holds 0x0F.
3. DEPTH=5, 12 writes interleaved with reads -> pointers wrap 4->0, data order preserved, count never exceeds 5.
4. Simultaneous wr_en and rd_en:
   - at count 0 -> count 1, underflow=1
   - at count 3 -> count stays 3, FIFO order preserved
   - at full -> count 15, overflow=1
5. FWFT=1, write 0xA5 into empty -> next cycle rd_valid=1 and rd_data=0xA5 with no rd_en. rd_en for one cycle -> empty=1.
6. Count 7, assert flush together with wr_en -> count 0, empty=1, write ignored, sticky flags kept. Then clr_err -> overflow=underflow=0. Reset asserted mid-stream -> all outputs at reset values asynchronously.
